// File: rtl/a2z_pkg.sv
// Shared types and constants for the vowel-elimination datapath.
package a2z_pkg;

  localparam int N_CHARS = 8;
  localparam int CHAR_W  = 8;

  typedef logic [CHAR_W-1:0] char_t;
  typedef char_t [N_CHARS-1:0] word_t;

  // Uppercase ASCII bounds, shared with the vowel stage.
  localparam char_t ASCII_A = 8'd65;
  localparam char_t ASCII_Z = 8'd90;

endpackage

// File: rtl/lsb_first_one.sv
// Lowest-set-bit priority encoder: index, one-hot and at-most-one flag.
// Purely combinational; no backpressure.
module lsb_first_one #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot,
  output logic                 onehot0
);

  localparam int IDX_W = $clog2(N);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot  = req & (~req + 1'b1);
  assign onehot0 = ((req & (req - 1'b1)) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/consonant_serializer.sv
// Streams the non-vowel characters of a masked word, index 0 first, one per cycle.
// Latency: accept at edge t, first beat visible after t; stalls hold all outputs stable.
module consonant_serializer
  import a2z_pkg::*;
#(
  parameter int N_CHARS = a2z_pkg::N_CHARS,
  parameter int CHAR_W  = a2z_pkg::CHAR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_CHARS*CHAR_W-1:0]    in_word,
  input  logic [N_CHARS-1:0]           in_vmask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHAR_W-1:0]            out_char,
  output logic [$clog2(N_CHARS)-1:0]   out_idx,
  output logic                         out_last,
  output logic                         empty_pulse
);

  localparam int IDX_W = $clog2(N_CHARS);

  logic [N_CHARS-1:0][CHAR_W-1:0] word_q;
  logic [N_CHARS-1:0]             keep_q;
  logic [N_CHARS-1:0]             sel_oh;
  logic [IDX_W-1:0]               sel;
  logic                           at_most_one;
  logic                           beat;
  logic                           accept;

  lsb_first_one #(.N(N_CHARS)) u_enc (
    .req     (keep_q),
    .idx     (sel),
    .onehot  (sel_oh),
    .onehot0 (at_most_one)
  );

  assign out_valid = |keep_q;
  assign out_char  = word_q[sel];
  assign out_idx   = sel;
  assign out_last  = out_valid & at_most_one;

  assign beat     = out_valid & out_ready;
  // Accepting on the last beat keeps consecutive words bubble-free.
  assign in_ready = ~out_valid | (beat & out_last);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      keep_q      <= '0;
      empty_pulse <= 1'b0;
    end else begin
      if (accept) begin
        word_q <= in_word;
        keep_q <= ~in_vmask;
      end else if (beat) begin
        keep_q <= keep_q & ~sel_oh;
      end
      empty_pulse <= accept & (&in_vmask);
    end
  end

endmodule

// File: doc/consonant_serializer.md
# consonant_serializer

Downstream stage of the vowel-elimination block. It accepts one 8-character word plus its per-character vowel mask per handshake and streams out only the non-vowel characters, one per cycle. Characters leave in index order, index 0 first, over a valid/ready interface with a last-beat flag. It turns the block's parallel word output into the byte stream consumed by the print/UART side of the design.

## Interface
Parameters:
- N_CHARS, 8, characters per word
- CHAR_W, 8, bits per character (ASCII)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  word + mask presented
- in_ready  out  1  block can accept a word this cycle
- in_word  in  N_CHARS*CHAR_W  packed word; char i = in_word[i*CHAR_W +: CHAR_W]
- in_vmask  in  N_CHARS  bit i = 1 → char i is a vowel (drop)
- out_valid  out  1  out_char valid
- out_ready  in  1  downstream accepts beat
- out_char  out  CHAR_W  current kept character
- out_idx  out  $clog2(N_CHARS)  original position of out_char in the word
- out_last  out  1  final kept character of the current word
- empty_pulse  out  1  one-cycle pulse: accepted word had no kept characters

## Operation
- Registers: word_q (N_CHARS*CHAR_W), keep_q (N_CHARS, 1 = char still to emit), state.
- States: IDLE (keep_q == 0), EMIT (keep_q != 0). State is equivalent to |keep_q and need not be a separate flop.
- Accept when in_valid & in_ready: word_q ← in_word, keep_q ← ~in_vmask.
- in_ready = (keep_q == 0) | (out_valid & out_ready & out_last). Back-to-back words therefore have no bubble.
- Output is combinational from registers:
  - out_valid = |keep_q
  - sel = index of lowest set bit of keep_q
  - out_char = word_q[sel]
  - out_idx = sel
  - out_last = keep_q has exactly one bit set
- Beat handshake (out_valid & out_ready): clear bit sel in keep_q. On the last beat, keep_q reaches 0 unless a new word is accepted in the same cycle, in which case the load wins.
- out_ready low: out_char, out_idx, out_last and out_valid hold stable. There is no retraction.
- Accepted word with in_vmask all ones: keep_q stays 0 and there are no beats. empty_pulse = 1 in the next cycle and in_ready stays high.
- in_valid while busy and not on the last beat: ignored. Upstream must hold its data.
- Mask bits are trusted. The block does not re-check for vowels.

## Timing
- Reset values: keep_q = 0, word_q = 0, empty_pulse = 0. Outputs: in_ready = 1, out_valid = 0, out_char = 0, out_idx = 0, out_last = 0.
- Reset asserted mid-word aborts immediately and asynchronously. Remaining characters are discarded and nothing is emitted after release.
- Latency: accept at edge t → out_valid at t+1 → first beat.
- Throughput: one kept character per cycle while out_ready = 1. A word with k kept characters occupies k cycles. k = 0 occupies 0 busy cycles.
- empty_pulse is registered and asserted exactly one cycle after the accepting edge.
- Simultaneous last beat and new accept: at the next cycle out_valid = 1, showing the new word's first kept character.

## Structure
- Shared package a2z_pkg:
  - N_CHARS and CHAR_W constants
  - typedef char_t (logic [CHAR_W-1:0])
  - typedef word_t (char_t [N_CHARS-1:0])
  - ASCII bound constants 'A' = 65 and 'Z' = 90, reused by the vowel stage
- One sub-module, lsb_first_one: parameterised N_CHARS priority encoder. It outputs the index and a one-hot of the lowest set bit, plus an onehot0 flag for out_last.
- The top level holds the registers and handshake glue. Target size is roughly 150 lines.

## Test plan
- Word "BCADEFGH" (65-based ASCII) with mask 0b00010100 (A at idx 2, E at idx 4), out_ready = 1: beats B,C,D,F,G,H with out_idx 0,1,3,5,6,7. out_last on H only. First beat is 1 cycle after accept.
- Word "AEIOUAEI" with mask 0xFF: no out_valid, empty_pulse high for exactly one cycle, in_ready stays 1.
- Mask 0x00, out_ready toggled 1,0,0,1,…: 8 beats in order. out_char and out_idx stable through every stall.
- Two words held on in_valid back-to-back, the first with 3 kept characters: second word accepted on the first word's out_last beat. Continuous out_valid with no idle cycle between words.
- rst_n pulsed low after 2 of 6 beats: out_valid drops asynchronously, in_ready = 1 after release, no residual beats. The next word streams correctly.
- Random words in range 65–90 with a reference-model vowel mask, 1000 words: concatenated output equals the input with A, E, I, O, U removed. Beat count equals popcount(~mask).
